led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//   Sequencer for the board LED datapath, clocked by the 48 MHz int_osc.
//   Replaces the fixed 2.4 Hz blink with a switch-configured stepping engine:
//   - s[3:2] selects the LED pattern; s[1:0] selects the step rate.
//   - A debounced push-button starts, pauses and resumes the sequence.
// PARAMETERS
//   TICK_DIV      20_000_000  int_osc cycles per step at rate 0 (2.4 Hz)
//   DEBOUNCE_CYC  480_000     cycles btn must be stable to register (10 ms)
// PORTS
//   int_osc  in   1  system clock, 48 MHz; all state on posedge
//   reset    in   1  asynchronous, active-high; clears all state
//   s        in   4  raw switches; [3:2] mode, [1:0] rate; asynchronous
//   btn      in   1  raw push-button, active-high, bouncy; asynchronous
//   led      out  3  LED pattern, registered
//   running  out  1  1 while in RUN, registered
// BEHAVIOUR
//   Reset (async):
//     - FSM=IDLE; led=000, running=0.
//     - Prescaler, debounce counter, btn_db and synchronizers all 0.
//   Input conditioning:
//     - btn and s each pass through a 2-FF synchronizer.
//     - btn_db takes the synced btn value only after it differs from btn_db
//       for DEBOUNCE_CYC consecutive cycles. Any bounce clears the count.
//     - press is a 1-cycle pulse on each btn_db 0->1; release generates nothing.
//     - Latency, btn rise to running change: at most DEBOUNCE_CYC+4 cycles.
//       Exactly one state change per press.
//   Step period:
//     - period = TICK_DIV >> rate, giving /1, /2, /4 or /8.
//     - rate is latched on RUN entry from IDLE and at every step.
//     - A rate change mid-period takes effect after the current step.
//     - Prescaler width is $clog2(TICK_DIV).
//   FSM:
//     IDLE  : led=000, prescaler=0. On press -> RUN:
//             mode latched, led <= seed(mode), prescaler=0.
//     RUN   : prescaler counts 0..period-1.
//             At period-1: step fires, prescaler -> 0, led advances.
//             On press -> PAUSE.
//     PAUSE : led and prescaler hold; running=0.
//             On press -> RUN, resuming from the held prescaler value.
//     There is no return to IDLE except by reset.
//   Patterns (mode = s[3:2]):
//     00 count : seed 000; led+1, wraps 111 -> 000.
//     01 walk  : seed 001; rotate left 001 -> 010 -> 100 -> 001.
//     10 bounce: seed 001, direction up.
//                Sequence 001 -> 010 -> 100 -> 010 -> 001 -> 010 ...
//                Direction reverses at 100 and at 001.
//     11 blink : seed 111; toggles 111 <-> 000.
//   Mode change:
//     - Sampled only at a step.
//     - If the synced mode differs from the active mode, the active mode is
//       updated and led <= seed(new mode) instead of advancing.
//   Simultaneous events:
//     - press in the same cycle as a step: the step completes (led advances)
//       and the FSM enters PAUSE.
//   Reset mid-operation: led=000 and running=0 immediately, asynchronously.
// TESTING (TICK_DIV=16, DEBOUNCE_CYC=4)
//   1. In RUN/blink, assert reset -> led=000, running=0 before the next edge;
//      after release, IDLE holds until a press.
//   2. btn high for 3 cycles, then low -> no change.
//      btn high for 10 cycles -> running=1 within 8 cycles; exactly one change.
//   3. s=0100 (walk, rate 0), press -> led=001, then 010, 100, 001 every 16 cycles.
//   4. s=0011 (count, rate 3, period 2) -> led increments every 2 cycles;
//      111 -> 000 wrap observed.
//   5. Bounce run -> 001,010,100,010,001; press mid-period -> led frozen
//      for 100 cycles; press again -> next step after the remaining count.
//   6. Running walk, switch s[3:2] to 11 mid-period -> led unchanged until
//      the step, then 111, then 000.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Switch-configured LED stepping engine clocked by int_osc. A debounced
//   push-button starts the sequence from IDLE, then alternately pauses and
//   resumes it. s[3:2] picks the pattern (count/walk/bounce/blink) and
//   s[1:0] picks the step rate (TICK_DIV >> rate cycles per step).
// Ports
//   int_osc  in   1  system clock, all state on posedge
//   reset    in   1  asynchronous active-high reset, clears all state
//   s        in   4  raw switches: [3:2] mode, [1:0] rate (asynchronous)
//   btn      in   1  raw push-button, active-high, bouncy (asynchronous)
//   led      out  3  LED pattern, registered
//   running  out  1  high while sequencing (RUN), registered
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV     = 20_000_000,
  parameter int unsigned DEBOUNCE_CYC = 480_000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] s,
  input  logic       btn,
  output logic [2:0] led,
  output logic       running
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  // One bit wider than the prescaler so a power-of-two TICK_DIV is representable.
  localparam logic [PW:0]   TICK    = (PW + 1)'(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef enum logic [1:0] {M_COUNT, M_WALK, M_BOUNCE, M_BLINK} mode_t;

  state_t        state;
  mode_t         mode_q;
  logic [1:0]    rate_q;
  logic          dir_up;
  logic [PW-1:0] presc;

  logic          btn_meta, btn_sync;
  logic [3:0]    s_meta, s_sync;
  logic [DW-1:0] db_cnt;
  logic          btn_db, btn_db_q;
  logic          press;

  mode_t         s_mode;
  logic [1:0]    s_rate;
  logic [PW:0]   period_full;
  logic [PW-1:0] period_last;
  logic          step;
  logic [2:0]    led_adv;
  logic          dir_adv;

  // ---------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      s_meta   <= '0;
      s_sync   <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      s_meta   <= s;
      s_sync   <= s_meta;
    end
  end

  assign s_mode = mode_t'(s_sync[3:2]);
  assign s_rate = s_sync[1:0];

  // ---------------------------------------------------------------------
  // Debounce: btn_db follows btn_sync only after DEBOUNCE_CYC consecutive
  // differing cycles; any agreement in between restarts the count.
  // ---------------------------------------------------------------------
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_sync != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= btn_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  // ---------------------------------------------------------------------
  // Step timing
  // ---------------------------------------------------------------------
  always_comb begin
    period_full = TICK >> rate_q;
    period_last = PW'(period_full - (PW + 1)'(1));
  end

  assign step = (state == RUN) && (presc == period_last);

  // ---------------------------------------------------------------------
  // Pattern advance for the active mode
  // ---------------------------------------------------------------------
  function automatic logic [2:0] seed(input mode_t m);
    case (m)
      M_COUNT:  seed = 3'b000;
      M_WALK:   seed = 3'b001;
      M_BOUNCE: seed = 3'b001;
      default:  seed = 3'b111;
    endcase
  endfunction

  always_comb begin
    led_adv = led;
    dir_adv = dir_up;
    case (mode_q)
      M_COUNT: led_adv = led + 3'd1;
      M_WALK:  led_adv = {led[1:0], led[2]};
      M_BOUNCE: begin
        // Turn around at either end; the end LED is lit once per sweep.
        if (dir_up) begin
          if (led[2]) begin
            led_adv = 3'b010;
            dir_adv = 1'b0;
          end else begin
            led_adv = led << 1;
          end
        end else begin
          if (led[0]) begin
            led_adv = 3'b010;
            dir_adv = 1'b1;
          end else begin
            led_adv = led >> 1;
          end
        end
      end
      default: led_adv = ~led;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      led     <= '0;
      running <= 1'b0;
      presc   <= '0;
      mode_q  <= M_COUNT;
      rate_q  <= '0;
      dir_up  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          led     <= '0;
          presc   <= '0;
          running <= 1'b0;
          if (press) begin
            state   <= RUN;
            running <= 1'b1;
            mode_q  <= s_mode;
            rate_q  <= s_rate;
            led     <= seed(s_mode);
            dir_up  <= 1'b1;
          end
        end
        RUN: begin
          if (step) begin
            presc  <= '0;
            rate_q <= s_rate;
            // A pending mode change replaces the advance with the new seed.
            if (s_mode != mode_q) begin
              mode_q <= s_mode;
              led    <= seed(s_mode);
              dir_up <= 1'b1;
            end else begin
              led    <= led_adv;
              dir_up <= dir_adv;
            end
          end else begin
            presc <= presc + PW'(1);
          end
          if (press) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Directed bench for led_pattern_sequencer with TICK_DIV=16 and
//   DEBOUNCE_CYC=4. A cycle-level behavioural model (pattern tables, elapsed
//   cycle count, consecutive-cycle debounce) is compared every cycle, and
//   hand-computed literals pin the key timings and values.
module tb_led_pattern_sequencer;

  localparam int unsigned TD = 16;
  localparam int unsigned DB = 4;

  logic       int_osc = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] s       = 4'b0000;
  logic       btn     = 1'b0;
  logic [2:0] led;
  logic       running;

  led_pattern_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB)) dut (
    .int_osc (int_osc),
    .reset   (reset),
    .s       (s),
    .btn     (btn),
    .led     (led),
    .running (running)
  );

  always #5 int_osc = ~int_osc;

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  bit       m_b1 = 0, m_b2 = 0;
  bit [3:0] m_s1 = 0, m_s2 = 0;
  bit       m_db = 0, m_dbp = 0;
  int       m_cnt = 0;
  bit       m_started = 0, m_run = 0;
  int       m_mode = 0, m_rate = 0, m_pos = 0, m_elapsed = 0;
  bit       m_press, m_step;
  int       run_total = 0;

  function automatic int pat(input int mode, input int pos);
    case (mode)
      0:       return pos;
      1:       return 1 << pos;
      2:       return (pos == 3) ? 2 : (1 << pos);
      default: return (pos == 0) ? 7 : 0;
    endcase
  endfunction

  function automatic int plen(input int mode);
    case (mode)
      0:       return 8;
      1:       return 3;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int exp_led();
    return m_started ? pat(m_mode, m_pos) : 0;
  endfunction

  always @(posedge int_osc or posedge reset) begin
    if (reset) begin
      m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0;
      m_db = 0; m_dbp = 0; m_cnt = 0;
      m_started = 0; m_run = 0;
      m_mode = 0; m_rate = 0; m_pos = 0; m_elapsed = 0;
    end else begin
      m_press = m_db && !m_dbp;
      m_step  = m_started && m_run && (m_elapsed == int'(TD >> m_rate) - 1);
      if (!m_started) begin
        if (m_press) begin
          m_started = 1; m_run = 1;
          m_mode = int'(m_s2[3:2]); m_rate = int'(m_s2[1:0]);
          m_pos = 0; m_elapsed = 0;
        end
      end else if (m_run) begin
        if (m_step) begin
          m_elapsed = 0;
          m_rate = int'(m_s2[1:0]);
          if (int'(m_s2[3:2]) != m_mode) begin
            m_mode = int'(m_s2[3:2]);
            m_pos = 0;
          end else begin
            m_pos = (m_pos + 1) % plen(m_mode);
          end
        end else begin
          m_elapsed++;
        end
        if (m_press) m_run = 0;
      end else if (m_press) begin
        m_run = 1;
      end
      m_dbp = m_db;
      if (m_b2 != m_db) begin
        m_cnt++;
        if (m_cnt == int'(DB)) begin
          m_db = m_b2;
          m_cnt = 0;
        end
      end else begin
        m_cnt = 0;
      end
      m_b2 = m_b1; m_b1 = btn;
      m_s2 = m_s1; m_s1 = s;
    end
  end

  always @(posedge int_osc) if (running === 1'b1) run_total <= run_total + 1;

  // ---------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic press();
    btn = 1'b1;
    fork
      begin
        repeat (10) @(negedge int_osc);
        btn = 1'b0;
      end
    join_none
  endtask

  task automatic wait_running(input logic want, output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge int_osc);
      cyc++;
      if (running === want) seen = 1;
    end
    check("wait_running_in_time", {31'b0, seen}, 32'd1);
  endtask

  task automatic wait_change(output int cyc, output logic [2:0] val);
    logic [2:0] prev;
    bit seen;
    prev = led;
    val  = led;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 400) begin
      @(negedge int_osc);
      cyc++;
      if (led !== prev) begin
        seen = 1;
        val  = led;
      end
    end
    check("wait_change_in_time", {31'b0, seen}, 32'd1);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int c, lat, chg, bad, base;
    logic [2:0] v, lat_led;
    logic prev_run;
    logic [2:0] walk_exp [3];
    logic [2:0] bnc_exp [4];
    walk_exp = '{3'b010, 3'b100, 3'b001};
    bnc_exp  = '{3'b100, 3'b010, 3'b001, 3'b010};

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge int_osc);
        check("cycle_led", {29'b0, led}, exp_led());
        check("cycle_running", {31'b0, running}, {31'b0, (m_started && m_run)});
      end
    join_none

    repeat (3) @(negedge int_osc);
    check("reset_led", {29'b0, led}, 32'd0);
    check("reset_running", {31'b0, running}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge int_osc);

    // Short glitch is ignored, a held press starts blink once.
    s = 4'b1100;
    btn = 1'b1;
    repeat (3) @(negedge int_osc);
    btn = 1'b0;
    repeat (20) @(negedge int_osc);
    check("short_press_ignored", {31'b0, running}, 32'd0);

    btn = 1'b1; lat = 0; chg = 0; lat_led = '0; prev_run = running;
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) btn = 1'b0;
      @(negedge int_osc);
      if (running !== prev_run) chg++;
      prev_run = running;
      if (running === 1'b1 && lat == 0) begin
        lat = i;
        lat_led = led;
      end
    end
    check("press_latency_le8", {31'b0, (lat >= 1 && lat <= 8)}, 32'd1);
    check("one_change_per_press", chg, 32'd1);
    check("blink_seed", {29'b0, lat_led}, 32'd7);

    // Asynchronous reset mid-run, then IDLE holds.
    #2 reset = 1'b1;
    #1;
    check("async_reset_led", {29'b0, led}, 32'd0);
    check("async_reset_running", {31'b0, running}, 32'd0);
    @(negedge int_osc);
    #2 reset = 1'b0;
    repeat (30) @(negedge int_osc);
    check("idle_hold_running", {31'b0, running}, 32'd0);
    check("idle_hold_led", {29'b0, led}, 32'd0);

    // Walk at rate 0: a step every 16 cycles.
    s = 4'b0100;
    press();
    wait_running(1'b1, c);
    check("walk_seed", {29'b0, led}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      wait_change(c, v);
      check("walk_value", {29'b0, v}, {29'b0, walk_exp[i]});
      check("walk_period", c, 32'd16);
    end

    // Count at rate 3 (period 2), switched right after a step.
    s = 4'b0011;
    wait_change(c, v);
    check("count_seed", {29'b0, v}, 32'd0);
    check("count_switch_at_step", c, 32'd16);
    for (int i = 1; i <= 8; i++) begin
      wait_change(c, v);
      check("count_value", {29'b0, v}, i % 8);
      check("count_period", c, 32'd2);
    end

    // Bounce at rate 0.
    s = 4'b1000;
    repeat (10) @(negedge int_osc);
    check("bounce_seed", {29'b0, led}, 32'd1);
    wait_change(c, v);
    check("bounce_first", {29'b0, v}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      wait_change(c, v);
      check("bounce_value", {29'b0, v}, {29'b0, bnc_exp[i]});
      check("bounce_period", c, 32'd16);
    end

    // Pause mid-period, hold 100 cycles, resume with the remaining count.
    base = run_total;
    repeat (5) @(negedge int_osc);
    press();
    wait_running(1'b0, c);
    check("pause_latency_le8", {31'b0, (c <= 8)}, 32'd1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge int_osc);
      if (led !== 3'b010 || running !== 1'b0) bad++;
    end
    check("pause_frozen", bad, 32'd0);
    press();
    wait_change(c, v);
    check("resume_value", {29'b0, v}, 32'd4);
    check("resume_run_cycles", run_total - base, 32'd16);

    // Walk, then switch to blink mid-period.
    s = 4'b0100;
    wait_change(c, v);
    check("walk2_seed", {29'b0, v}, 32'd1);
    check("walk2_period", c, 32'd16);
    repeat (4) @(negedge int_osc);
    s = 4'b1100;
    wait_change(c, v);
    check("blink_switch_value", {29'b0, v}, 32'd7);
    check("blink_switch_remaining", c, 32'd12);
    wait_change(c, v);
    check("blink_toggle", {29'b0, v}, 32'd0);
    check("blink_period", c, 32'd16);

    repeat (3) @(negedge int_osc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
